// File: rtl/serial_bcd_to_binary.sv
// Serial BCD-to-binary converter: rebuilds a binary value from decimal digits
// received most significant first, using a sequential shift-add multiply by ten.
module serial_bcd_to_binary #(
  parameter int WIDTH      = 13,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       digit,
  input  logic             digit_valid,
  input  logic             digit_last,
  output logic             digit_ready,
  output logic [WIDTH-1:0] value,
  output logic             value_valid,
  output logic             overflow,
  output logic             error
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [WIDTH+3:0] MAX_VALUE = {{4{1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [2:0] {IDLE, WAIT, MUL, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [3:0]       dig;
  logic             last;
  logic [CW-1:0]    count;
  logic [WIDTH+3:0] prod;
  logic [WIDTH+3:0] sum;
  logic [WIDTH-1:0] next_acc;

  // Product and sum are kept four bits wider than the result so that an
  // out-of-range total is detected instead of silently wrapping.
  always_comb begin
    sum      = prod + {{WIDTH{1'b0}}, dig};
    next_acc = (sum > MAX_VALUE) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      dig         <= '0;
      last        <= 1'b0;
      count       <= '0;
      prod        <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      overflow    <= 1'b0;
      error       <= 1'b0;
      digit_ready <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      // Start aborts whatever is in flight and takes priority over a digit.
      if (start) begin
        state       <= WAIT;
        acc         <= '0;
        count       <= '0;
        overflow    <= 1'b0;
        error       <= 1'b0;
        digit_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            digit_ready <= 1'b0;
          end
          WAIT: begin
            if (digit_valid && digit_ready) begin
              dig         <= digit;
              last        <= digit_last;
              count       <= count + 1'b1;
              digit_ready <= 1'b0;
              if (digit > 4'd9) begin
                error       <= 1'b1;
                value       <= '0;
                value_valid <= 1'b1;
                state       <= DONE;
              end else begin
                state <= MUL;
              end
            end
          end
          MUL: begin
            prod  <= ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1);
            state <= ADD;
          end
          ADD: begin
            acc <= next_acc;
            if (sum > MAX_VALUE) begin
              overflow <= 1'b1;
            end
            // Result is published on entry to DONE so the strobe is high
            // exactly during the DONE cycle.
            if (last || (count == CW'(MAX_DIGITS))) begin
              value       <= error ? '0 : next_acc;
              value_valid <= 1'b1;
              state       <= DONE;
            end else begin
              digit_ready <= 1'b1;
              state       <= WAIT;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_bcd_to_binary.sv
// Self-checking bench for serial_bcd_to_binary: table-driven frames plus
// directed sequences for abort, ignored digits and asynchronous reset.
module tb_serial_bcd_to_binary;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        digit_last;
  logic        digit_ready;
  logic [12:0] value;
  logic        value_valid;
  logic        overflow;
  logic        error;

  int testsRun  = 0;
  int testsFail = 0;
  int vvCount   = 0;

  typedef struct {
    logic [15:0] digs;
    int          n;
    int          lastIdx;
    int          expValue;
    int          expOvf;
    int          expErr;
    int          expLat;
  } vec_t;

  vec_t vecs [8];

  serial_bcd_to_binary #(.WIDTH(13), .MAX_DIGITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_last  (digit_last),
    .digit_ready (digit_ready),
    .value       (value),
    .value_valid (value_valid),
    .overflow    (overflow),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (value_valid) vvCount++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendDigit(input logic [3:0] d, input logic l);
    int w = 0;
    while (!digit_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!digit_ready) begin
      testsRun++;
      testsFail++;
      $display("[TB] FAIL ready_timeout: got ready=0 after %0d cycles, expected ready=1", w);
    end
    digit       = d;
    digit_valid = 1'b1;
    digit_last  = l;
    @(negedge clk);
    digit_valid = 1'b0;
    digit_last  = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 1;
    while (!value_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic applyStimulus(input int idx);
    int lat;
    logic [15:0] cur;
    cur = vecs[idx].digs;
    pulseStart();
    checkOutput($sformatf("v%0d_ready_after_start", idx), digit_ready, 1);
    checkOutput($sformatf("v%0d_err_after_start", idx), error, 0);
    checkOutput($sformatf("v%0d_ovf_after_start", idx), overflow, 0);
    for (int j = 0; j < vecs[idx].n; j++) begin
      sendDigit(cur[15-4*j -: 4], (j == vecs[idx].lastIdx));
    end
    waitResult(lat);
    checkOutput($sformatf("v%0d_latency", idx), lat, vecs[idx].expLat);
    checkOutput($sformatf("v%0d_value", idx), value, vecs[idx].expValue);
    checkOutput($sformatf("v%0d_overflow", idx), overflow, vecs[idx].expOvf);
    checkOutput($sformatf("v%0d_error", idx), error, vecs[idx].expErr);
    @(negedge clk);
    checkOutput($sformatf("v%0d_strobe_one_cycle", idx), value_valid, 0);
    checkOutput($sformatf("v%0d_ready_idle", idx), digit_ready, 0);
  endtask

  initial begin
    int lat;
    int vvBefore;

    vecs[0] = '{16'h1234, 4, 3,    1234, 0, 0, 3};
    vecs[1] = '{16'h8191, 4, 3,    8191, 0, 0, 3};
    vecs[2] = '{16'h8192, 4, 3,    8191, 1, 0, 3};
    vecs[3] = '{16'h0075, 4, -1,     75, 0, 0, 3};
    vecs[4] = '{16'h0000, 1, 0,       0, 0, 0, 3};
    vecs[5] = '{16'h3A00, 2, -1,      0, 0, 1, 1};
    vecs[6] = '{16'h9999, 4, -1,   8191, 1, 0, 3};
    vecs[7] = '{16'h4200, 2, 1,      42, 0, 0, 3};

    rst_n       = 1'b0;
    start       = 1'b0;
    digit       = 4'd0;
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", digit_ready, 0);
    checkOutput("reset_value", value, 0);
    checkOutput("reset_valid", value_valid, 0);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_error", error, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(i);
    end

    // Abort after 9,9; a digit offered together with Start must be dropped.
    vvBefore = vvCount;
    pulseStart();
    sendDigit(4'd9, 1'b0);
    sendDigit(4'd9, 1'b0);
    while (!digit_ready) @(negedge clk);
    start       = 1'b1;
    digit       = 4'd7;
    digit_valid = 1'b1;
    digit_last  = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    checkOutput("abort_ready", digit_ready, 1);
    sendDigit(4'd4, 1'b1);
    waitResult(lat);
    checkOutput("abort_latency", lat, 3);
    checkOutput("abort_value", value, 4);
    repeat (2) @(negedge clk);
    checkOutput("abort_strobe_count", vvCount - vvBefore, 1);

    // Digits offered in IDLE are ignored.
    vvBefore    = vvCount;
    digit       = 4'd5;
    digit_valid = 1'b1;
    digit_last  = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_ready", digit_ready, 0);
    checkOutput("idle_no_strobe", vvCount - vvBefore, 0);
    checkOutput("idle_value_held", value, 4);
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    pulseStart();
    sendDigit(4'd6, 1'b1);
    waitResult(lat);
    checkOutput("single6_value", value, 6);
    @(negedge clk);

    // Reset asserted while in ADD with DigitValid held high throughout.
    pulseStart();
    digit       = 4'd8;
    digit_valid = 1'b1;
    digit_last  = 1'b0;
    @(negedge clk);
    checkOutput("mul_ready", digit_ready, 0);
    @(negedge clk);
    checkOutput("add_ready", digit_ready, 0);
    vvBefore = vvCount;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", digit_ready, 0);
    checkOutput("rst_value", value, 0);
    checkOutput("rst_valid", value_valid, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_ready", digit_ready, 0);
    checkOutput("post_rst_no_strobe", vvCount - vvBefore, 0);
    digit_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
